// File: rtl/seg_p2s_pkg.sv
// Shared types and default parameters for the segment-display serialiser.
package seg_p2s_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned DIV_DEF    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LATCH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/seg_p2s_if.sv
// Request/serial bundle between a frame producer and the serialiser.
interface seg_p2s_if
    import seg_p2s_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              start;
    logic [DATA_W-1:0] data;
    logic              sclk;
    logic              sdat;
    logic              latch;
    logic              busy;
    logic              done;

    modport master (
        output start, data,
        input  sclk, sdat, latch, busy, done
    );

    modport slave (
        input  start, data,
        output sclk, sdat, latch, busy, done
    );
endinterface

// File: rtl/seg_p2s_div.sv
// Phase counter: terminal count every DIV cycles, restarted by clr.
module seg_p2s_div
    import seg_p2s_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tc_c
);
    localparam int unsigned CNT_W = $clog2(DIV + 1);

    logic [CNT_W-1:0] cnt;

    assign tc_c = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tc_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/seg_p2s_tx.sv
// Parallel-to-serial transmitter feeding a chain of display shift registers.
module seg_p2s_tx
    import seg_p2s_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DIV    = DIV_DEF
) (
    input  logic     clk,
    input  logic     rst,
    seg_p2s_if.slave bus
);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    state_t            state, state_nx;
    logic [DATA_W-1:0] sr, sr_nx;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nx;
    logic              sdat_r, sdat_nx;
    logic              sclk_r, latch_r, busy_r, done_r;
    logic              phase_clr_c, phase_tc_c;

    seg_p2s_div #(.DIV(DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (phase_clr_c),
        .tc_c (phase_tc_c)
    );

    // Next-state, shift and bit-count decisions
    always_comb begin
        state_nx    = state;
        sr_nx       = sr;
        bit_cnt_nx  = bit_cnt;
        sdat_nx     = sdat_r;
        phase_clr_c = 1'b0;

        case (state)
            ST_IDLE: begin
                phase_clr_c = 1'b1;
                if (bus.start) begin
                    sr_nx      = bus.data;
                    bit_cnt_nx = BIT_W'(DATA_W);
                    state_nx   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (phase_tc_c) state_nx = ST_HIGH;
            end
            ST_HIGH: begin
                if (phase_tc_c) begin
                    sr_nx      = sr << 1;
                    bit_cnt_nx = bit_cnt - BIT_W'(1);
                    state_nx   = (bit_cnt == BIT_W'(1)) ? ST_LATCH : ST_SETUP;
                end
            end
            ST_LATCH: begin
                if (phase_tc_c) state_nx = ST_DONE;
            end
            ST_DONE: begin
                phase_clr_c = 1'b1;
                state_nx    = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Data only moves when a new bit period opens, keeping sdat quiet under sclk high
        if (state_nx == ST_SETUP && state != ST_SETUP) sdat_nx = sr_nx[DATA_W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            sdat_r  <= 1'b0;
            sclk_r  <= 1'b0;
            latch_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_nx;
            sr      <= sr_nx;
            bit_cnt <= bit_cnt_nx;
            sdat_r  <= sdat_nx;
            sclk_r  <= (state_nx == ST_HIGH);
            latch_r <= (state_nx == ST_LATCH);
            busy_r  <= (state_nx == ST_SETUP) || (state_nx == ST_HIGH) || (state_nx == ST_LATCH);
            done_r  <= (state_nx == ST_DONE);
        end
    end

    assign bus.sclk  = sclk_r;
    assign bus.sdat  = sdat_r;
    assign bus.latch = latch_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
endmodule
